// File: rtl/gated_sample_packer_if.sv
// gated_sample_packer_if: valid/ready stream carrying packed sample words
//   valid  master->slave  FIFO head holds a word
//   ready  slave->master  consumer takes the head this edge
//   data   master->slave  packed word, lane 0 in the low DATA_W bits
//   count  master->slave  number of valid lanes in data
interface gated_sample_packer_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) ();
  logic                             valid;
  logic                             ready;
  logic [DATA_W*LANES-1:0]          data;
  logic [$clog2(LANES+1)-1:0]       count;
  modport master (output valid, data, count, input ready);
  modport slave  (input valid, data, count, output ready);
endinterface

// File: rtl/gated_sample_packer.sv
// gated_sample_packer: packs enable-qualified samples into words and queues them in a FIFO
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   en_i          sample qualifier
//   sample_in_i   gated sample
//   flush_i       push the current partial word
//   clear_ovf_i   clears the sticky overflow flag
//   fifo_level_o  words currently queued
//   overflow_o    sticky: a completed word was dropped
//   m             master stream port (valid/ready/data/count)
module gated_sample_packer #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            en_i,
  input  logic [DATA_W-1:0]               sample_in_i,
  input  logic                            flush_i,
  input  logic                            clear_ovf_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o,
  output logic                            overflow_o,
  gated_sample_packer_if.master           m
);
  localparam int LW    = $clog2(LANES);
  localparam int CNT_W = $clog2(LANES+1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVW   = $clog2(FIFO_DEPTH+1);

  typedef enum logic {EMPTY, FILL} state_t;

  typedef struct packed {
    logic [LANES-1:0][DATA_W-1:0] data;
    logic [CNT_W-1:0]             cnt;
  } entry_t;

  state_t                       state_q, state_d;
  logic [LW-1:0]                lane_q, lane_d;
  logic [LANES-1:0][DATA_W-1:0] lanes_q, lanes_d, fill_word;
  logic [CNT_W-1:0]             filled;
  logic                         push, pop, push_ok, drop;
  entry_t                       mem_q [FIFO_DEPTH];
  logic [AW-1:0]                wr_q, wr_d, rd_q, rd_d;
  logic [LVW-1:0]               level_q, level_d;
  logic                         ovf_q, ovf_d;

  // The word as it stands after this edge's sample; lanes past the fill point are already 0.
  always_comb begin
    fill_word = lanes_q;
    if (en_i) fill_word[lane_q] = sample_in_i;
  end

  assign filled  = CNT_W'(lane_q) + CNT_W'(en_i);
  // A completing sample and a flush on the same edge still make a single push.
  assign push    = (en_i && lane_q == LW'(LANES-1)) || (flush_i && (state_q == FILL || en_i));
  assign lane_d  = push ? '0 : lane_q + LW'(en_i);
  assign lanes_d = push ? '0 : fill_word;
  assign state_d = push ? EMPTY : (en_i ? FILL : state_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      lane_q  <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      lanes_q <= lanes_d;
    end
  end

  // A pop on the same edge frees a slot, so a full FIFO can still accept the push.
  assign pop     = m.valid && m.ready;
  assign push_ok = push && (level_q < LVW'(FIFO_DEPTH) || pop);
  assign drop    = push && !push_ok;
  assign wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
  assign rd_d    = pop ? rd_q + 1'b1 : rd_q;
  assign level_d = level_q + LVW'(push_ok) - LVW'(pop);
  assign ovf_d   = drop || (ovf_q && !clear_ovf_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: it is only visible through the level-gated head.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= '{data: fill_word, cnt: filled};
  end

  assign m.valid      = level_q != '0;
  assign m.data       = m.valid ? mem_q[rd_q].data : '0;
  assign m.count      = m.valid ? mem_q[rd_q].cnt : '0;
  assign fifo_level_o = level_q;
  assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_gated_sample_packer.sv
// tb_gated_sample_packer: directed self-checking bench for gated_sample_packer
module tb_gated_sample_packer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [7:0] sample;
  logic       flush;
  logic       clear_ovf;
  logic [2:0] level;
  logic       ovf;
  int         n_cmp = 0;
  int         n_err = 0;

  gated_sample_packer_if bus ();

  gated_sample_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en_i         (en),
    .sample_in_i  (sample),
    .flush_i      (flush),
    .clear_ovf_i  (clear_ovf),
    .fifo_level_o (level),
    .overflow_o   (ovf),
    .m            (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [7:0] v);
    en = 1'b1;
    sample = v;
    tick();
    en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] d, input logic [2:0] c);
    chk({tag, ".valid"}, 64'(bus.valid), 64'(v));
    chk({tag, ".data"}, 64'(bus.data), 64'(d));
    chk({tag, ".count"}, 64'(bus.count), 64'(c));
  endtask

  initial begin
    logic [31:0] exp4 [4];
    logic [1:0]  pat6 [6];
    reset_n = 1'b0; en = 1'b0; sample = '0; flush = 1'b0; clear_ovf = 1'b0; bus.ready = 1'b0;
    #12;
    chk_head("reset", 1'b0, 32'h0, 3'd0);
    chk("reset.level", 64'(level), 64'd0);
    chk("reset.ovf", 64'(ovf), 64'd0);
    reset_n = 1'b1;
    tick();

    bus.ready = 1'b1;
    smp(8'h01); smp(8'h02); smp(8'h03);
    chk("t1.partial_valid", 64'(bus.valid), 64'd0);
    smp(8'h04);
    chk_head("t1.word", 1'b1, 32'h04030201, 3'd4);
    chk("t1.level", 64'(level), 64'd1);
    tick();
    chk_head("t1.popped", 1'b0, 32'h0, 3'd0);

    smp(8'hAA); smp(8'hBB);
    flush = 1'b1; tick(); flush = 1'b0;
    chk_head("t2.flush", 1'b1, 32'h0000BBAA, 3'd2);
    tick();
    chk("t2.popped", 64'(bus.valid), 64'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t2.empty_flush", 64'(bus.valid), 64'd0);
    smp(8'h51); smp(8'h52); smp(8'h53);
    en = 1'b1; sample = 8'h54; flush = 1'b1; tick(); en = 1'b0; flush = 1'b0;
    chk_head("t2.flush_full", 1'b1, 32'h54535251, 3'd4);
    tick();
    chk("t2.single_push", 64'(bus.valid), 64'd0);

    bus.ready = 1'b0;
    for (int i = 0; i < 20; i++) smp(8'(i + 1));
    chk("t3.level", 64'(level), 64'd4);
    chk("t3.ovf", 64'(ovf), 64'd1);
    exp4 = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    bus.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("t3.drain%0d", k), 1'b1, exp4[k], 3'd4);
      tick();
    end
    chk("t3.drained", 64'(level), 64'd0);
    chk("t3.ovf_sticky", 64'(ovf), 64'd1);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    chk("t3.ovf_clear", 64'(ovf), 64'd0);

    bus.ready = 1'b0;
    for (int i = 0; i < 19; i++) smp(8'(8'h21 + i));
    chk("t4.full", 64'(level), 64'd4);
    bus.ready = 1'b1;
    smp(8'h34);
    chk("t4.level", 64'(level), 64'd4);
    chk("t4.ovf", 64'(ovf), 64'd0);
    exp4 = '{32'h28272625, 32'h2C2B2A29, 32'h302F2E2D, 32'h34333231};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4.drain%0d", k), 64'(bus.data), 64'(exp4[k]));
      tick();
    end
    chk("t4.drained", 64'(level), 64'd0);

    bus.ready = 1'b0;
    for (int i = 0; i < 7; i++) smp(8'(8'h60 + i));
    chk("t5.pre_valid", 64'(bus.valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_head("t5.async", 1'b0, 32'h0, 3'd0);
    chk("t5.level", 64'(level), 64'd0);
    tick();
    reset_n = 1'b1;
    bus.ready = 1'b1;
    smp(8'h10); smp(8'h11); smp(8'h12); smp(8'h13);
    chk_head("t5.word", 1'b1, 32'h13121110, 3'd4);
    tick();

    pat6 = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1};
    for (int i = 0; i < 6; i++) begin
      en = pat6[i][0];
      sample = 8'(i + 1);
      tick();
    end
    en = 1'b0;
    chk_head("t6.gated", 1'b1, 32'h06050301, 3'd4);
    tick();
    bus.ready = 1'b0;
    for (int i = 0; i < 20; i++) smp(8'(8'h80 + i));
    chk("t6.ovf_set", 64'(ovf), 64'd1);
    smp(8'hA0); smp(8'hA1); smp(8'hA2);
    clear_ovf = 1'b1;
    smp(8'hA3);
    chk("t6.set_wins", 64'(ovf), 64'd1);
    tick();
    clear_ovf = 1'b0;
    chk("t6.cleared", 64'(ovf), 64'd0);
    chk("t6.level", 64'(level), 64'd4);
    chk("t6.head", 64'(bus.data), 64'h83828180);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
